key_input: RTL

KEY_INPUT -- requirements
Module: key_input

---
 rtl/key_input_pkg.sv | 19 +
 rtl/key_debounce.sv | 52 +++++
 rtl/key_input.sv | 80 ++++++++
 3 files changed

// File: rtl/key_input_pkg.sv
// Purpose : shared constants for the key input port (key count, bus width, busin field offsets).
// Latency : n/a (package only).
// Backpressure: n/a.
package key_input_pkg;

    localparam int KEY_COUNT = 4;
    localparam int BUS_WIDTH = 16;

    // busin field layout: debounced levels in the low nibble, sticky press events above
    localparam int LEVEL_LSB = 0;
    localparam int EVENT_LSB = 4;

    // Counter width able to hold cycles-1; never narrower than one bit so that
    // a single-cycle debounce still has a legal counter.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Purpose : two-flop synchronizer plus debounce for one key; emits stable level and a rise pulse.
// Latency : 2 sync cycles + DEBOUNCE_CYCLES stable cycles before a new level is accepted.
// Backpressure: none (free-running sampler).
// Ports   : clk, reset_bar (async active-low), key_raw (asynchronous key level),
//           level (debounced level), rise (one-cycle pulse on the cycle level goes 0->1).
module key_debounce
    import key_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic reset_bar,
    input  logic key_raw,
    output logic level,
    output logic rise
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;
    logic          accept;

    // Accept on the last differing cycle; counter is cleared here, so it never wraps.
    assign accept = (sync_2 != level) && (cnt == CNT_MAX);
    // Combinational so the event flag in the top sets on the same edge that level rises.
    assign rise   = accept && sync_2;

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= key_raw;
            sync_2 <= sync_1;
            if (sync_2 == level) begin
                // Agreement (including a bounce back mid-count) restarts the count.
                cnt <= '0;
            end else if (accept) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_input.sv
// Purpose : memory-mapped 4-key input port; debounced levels (and optional sticky press flags) on busin.
// Latency : busin is combinational from DO/addr (zero latency); key changes appear after debounce.
// Backpressure: none; a read completes on the cycle select falls.
// Ports   : clk, reset_bar (async active-low), key[3:0] raw keys (1 = pressed), addr[15:0],
//           DO (CPU reading I/O), busin[15:0] data to CPU (0 when not selected).
// Option  : define KEY_INPUT_EVENT_LATCH_EN to return sticky press flags on busin[7:4],
//           cleared when a read completes; otherwise busin[7:4] reads 0.
module key_input
    import key_input_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 120000,
    parameter logic [15:0] BASE_ADDR       = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_bar,
    input  logic [3:0]  key,
    input  logic [15:0] addr,
    input  logic        DO,
    output logic [15:0] busin
);

    logic [KEY_COUNT-1:0] level;
    logic [KEY_COUNT-1:0] rise;
    logic [KEY_COUNT-1:0] events;
    logic                 select;
    logic                 select_d;
    logic                 read_done;

    for (genvar i = 0; i < KEY_COUNT; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset_bar(reset_bar),
            .key_raw  (key[i]),
            .level    (level[i]),
            .rise     (rise[i])
        );
    end

    assign select    = DO && (addr == BASE_ADDR);
    assign read_done = select_d && !select;

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            select_d <= 1'b0;
        end else begin
            select_d <= select;
        end
    end

`ifdef KEY_INPUT_EVENT_LATCH_EN
    logic [KEY_COUNT-1:0] flags;

    // Set has priority over the read-completion clear so a press landing on
    // the closing cycle of a read is not lost.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            flags <= '0;
        end else begin
            flags <= (flags & ~{KEY_COUNT{read_done}}) | rise;
        end
    end

    assign events = flags;
`else
    logic unused_evt;
    assign unused_evt = ^{rise, read_done};
    assign events     = '0;
`endif

    always_comb begin
        busin = '0;
        if (select) begin
            busin[LEVEL_LSB +: KEY_COUNT] = level;
            busin[EVENT_LSB +: KEY_COUNT] = events;
        end
    end

endmodule
